// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one operand bit pair per cycle to an external full-adder cell.
// Optional macro SERIAL_ADD_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_i0,
    output logic             fa_i1,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             fa_i0_q, fa_i0_d;
    logic             fa_i1_q, fa_i1_d;
    logic             fa_ci_q, fa_ci_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q here is the carry into the MSB
                    ovf_d   = carry_q ^ fa_co;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Cell inputs are pre-registered so they mirror A[0]/B[0]/carry while in RUN
        busy_d  = (state_d != IDLE);
        fa_i0_d = (state_d == RUN) ? a_d[0]  : 1'b0;
        fa_i1_d = (state_d == RUN) ? b_d[0]  : 1'b0;
        fa_ci_d = (state_d == RUN) ? carry_d : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            fa_i0_q <= 1'b0;
            fa_i1_q <= 1'b0;
            fa_ci_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            fa_i0_q <= fa_i0_d;
            fa_i1_q <= fa_i1_d;
            fa_ci_q <= fa_ci_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign fa_i0 = fa_i0_q;
    assign fa_i1 = fa_i1_q;
    assign fa_ci = fa_ci_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with a behavioural full-adder cell on the fa_* ports.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       fa_i0, fa_i1, fa_ci, fa_s, fa_co;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign fa_s  = fa_i0 ^ fa_i1 ^ fa_ci;
    assign fa_co = (fa_i0 & fa_i1) | (fa_i0 & fa_ci) | (fa_i1 & fa_ci);

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .fa_i0(fa_i0), .fa_i1(fa_i1), .fa_ci(fa_ci), .fa_s(fa_s), .fa_co(fa_co)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    // Stimulus only: runs one addition and records what the DUT showed
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input bit inject,
                          output int done_edge, output int done_cnt,
                          output logic [7:0] s, output logic c, output logic o,
                          output logic [7:0] f0, output logic [7:0] f1, output logic ci0,
                          output logic busy_at_done, output logic busy_after,
                          output logic [7:0] s_hold);
        done_edge = 0; done_cnt = 0; s = '0; c = 1'b0; o = 1'b0;
        f0 = '0; f1 = '0; busy_at_done = 1'b0; busy_after = 1'b1; s_hold = '0;
        @(negedge clk);
        start = 1'b1; a = av; b = bv; cin = cv;
        @(posedge clk); #1;
        f0[0] = fa_i0; f1[0] = fa_i1; ci0 = fa_ci;
        start = 1'b0; a = 8'h5C; b = 8'hC3; cin = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k < 8) begin
                f0[k] = fa_i0;
                f1[k] = fa_i1;
            end
            if (done) begin
                done_cnt++;
                if (done_edge == 0) begin
                    done_edge = k;
                    s = sum; c = cout; busy_at_done = busy;
`ifdef SERIAL_ADD_OVF_EN
                    o = ovf;
`endif
                end
            end
            if (k == 9)  busy_after = busy;
            if (k == 11) s_hold = sum;
            if (inject && k == 3) begin
                start = 1'b1; a = 8'h11; b = 8'h11; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sum, cout, fa_i0, fa_i1, fa_ci} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {busy, done, sum, cout, fa_i0, fa_i1, fa_ci});
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b, expected 0", ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed add vectors: {a, b, cin, sum, cout, ovf}
    task automatic test_add();
        logic [7:0] tv_a [6] = '{8'hFF, 8'h00, 8'hA5, 8'hFF, 8'h7F, 8'h10};
        logic [7:0] tv_b [6] = '{8'h01, 8'h00, 8'h5A, 8'hFF, 8'h01, 8'h20};
        logic       tv_c [6] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
        logic [7:0] tv_s [6] = '{8'h00, 8'h01, 8'h00, 8'hFF, 8'h80, 8'h30};
        logic       tv_o [6] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        logic       tv_v [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
        int de, dc;
        logic [7:0] s, f0, f1, sh;
        logic c, o, ci0, bd, ba;
        for (int i = 0; i < 6; i++) begin
            run_op(tv_a[i], tv_b[i], tv_c[i], 1'b0, de, dc, s, c, o, f0, f1, ci0, bd, ba, sh);
            checks++;
            if (de !== 8 || dc !== 1) begin
                errors++;
                $display("FAIL add%0d_done_timing: edge %0d count %0d, expected edge 8 count 1", i, de, dc);
            end
            checks++;
            if (s !== tv_s[i] || c !== tv_o[i]) begin
                errors++;
                $display("FAIL add%0d_result: sum %h cout %b, expected sum %h cout %b", i, s, c, tv_s[i], tv_o[i]);
            end
            checks++;
            if (f0 !== tv_a[i] || f1 !== tv_b[i] || ci0 !== tv_c[i]) begin
                errors++;
                $display("FAIL add%0d_fa_bits: i0 %h i1 %h ci %b, expected %h %h %b",
                         i, f0, f1, ci0, tv_a[i], tv_b[i], tv_c[i]);
            end
            checks++;
            if (bd !== 1'b1 || ba !== 1'b0 || sh !== tv_s[i]) begin
                errors++;
                $display("FAIL add%0d_busy_hold: busy@done %b busy@idle %b held sum %h, expected 1 0 %h",
                         i, bd, ba, sh, tv_s[i]);
            end
`ifdef SERIAL_ADD_OVF_EN
            checks++;
            if (o !== tv_v[i]) begin
                errors++;
                $display("FAIL add%0d_ovf: got %b, expected %b", i, o, tv_v[i]);
            end
`endif
        end
`ifdef SERIAL_ADD_OVF_EN
        run_op(8'h80, 8'h80, 1'b0, 1'b0, de, dc, s, c, o, f0, f1, ci0, bd, ba, sh);
        checks++;
        if (s !== 8'h00 || c !== 1'b1 || o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_neg: sum %h cout %b ovf %b, expected 00 1 1", s, c, o);
        end
`endif
    endtask

    task automatic test_start_ignored();
        int de, dc;
        logic [7:0] s, f0, f1, sh;
        logic c, o, ci0, bd, ba;
        run_op(8'h03, 8'h04, 1'b0, 1'b1, de, dc, s, c, o, f0, f1, ci0, bd, ba, sh);
        checks++;
        if (s !== 8'h07 || c !== 1'b0 || de !== 8 || dc !== 1 || ba !== 1'b0) begin
            errors++;
            $display("FAIL start_in_run: sum %h cout %b edge %0d count %0d idle busy %b, expected 07 0 8 1 0",
                     s, c, de, dc, ba);
        end
    endtask

    task automatic test_reset_mid_run();
        int de, dc, seen;
        logic [7:0] s, f0, f1, sh;
        logic c, o, ci0, bd, ba;
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout, fa_i0, fa_i1, fa_ci} !== 13'd0) begin
            errors++;
            $display("FAIL mid_run_reset_clear: got %b, expected all zero",
                     {busy, done, sum, cout, fa_i0, fa_i1, fa_ci});
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_run_reset_quiet: %0d cycles with done/busy, expected 0", seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, de, dc, s, c, o, f0, f1, ci0, bd, ba, sh);
        checks++;
        if (s !== 8'h46 || c !== 1'b0 || de !== 8 || dc !== 1) begin
            errors++;
            $display("FAIL after_reset_add: sum %h cout %b edge %0d count %0d, expected 46 0 8 1", s, c, de, dc);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bb_a [3] = '{8'h01, 8'h10, 8'hF0};
        logic [7:0] bb_b [3] = '{8'h02, 8'h20, 8'h20};
        logic [7:0] bb_s [3] = '{8'h03, 8'h30, 8'h10};
        logic       bb_c [3] = '{1'b0,  1'b0,  1'b1};
        int early;
        @(negedge clk);
        start = 1'b1; a = bb_a[0]; b = bb_b[0]; cin = 1'b0;
        for (int op = 0; op < 3; op++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b%0d_accept: busy %b, expected 1", op, busy);
            end
            if (op < 2) begin
                a = bb_a[op+1]; b = bb_b[op+1];
            end
            early = 0;
            for (int k = 1; k < 8; k++) begin
                @(posedge clk); #1;
                if (done || !busy) early++;
            end
            @(posedge clk); #1;
            checks++;
            if (early !== 0 || done !== 1'b1 || sum !== bb_s[op] || cout !== bb_c[op]) begin
                errors++;
                $display("FAIL b2b%0d_result: early %0d done %b sum %h cout %b, expected 0 1 %h %b",
                         op, early, done, sum, cout, bb_s[op], bb_c[op]);
            end
            if (op == 2) start = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL b2b%0d_gap: busy %b done %b, expected 0 0", op, busy, done);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy %b, expected 0 once start drops", busy);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
